// File: rtl/ds_scan_multi_if.sv
// ds_scan_multi_if: byte-layer command/response bus between the scan controller and ds_intf_byte
interface ds_scan_multi_if;
  logic rst_en;
  logic wr_en;
  logic [7:0] wdata;
  logic rd_en;
  logic [7:0] rdata;
  logic rdata_vld;
  logic rdy;
  modport master(output rst_en, wr_en, wdata, rd_en, input rdata, rdata_vld, rdy);
  modport slave(input rst_en, wr_en, wdata, rd_en, output rdata, rdata_vld, rdy);
endinterface

// File: rtl/ds_scan_multi.sv
// ds_scan_multi: broadcast Convert T, then Match ROM + scratchpad read per channel with alarms; DS_SCAN_CRC_EN adds 9-byte read and CRC-8 check
module ds_scan_multi #(
  parameter int CH_NUM = 4,
  parameter int CH_W = 2,
  parameter logic [64*CH_NUM-1:0] ROM_CODES = '0,
  parameter int CONV_CYC = 37_500_000,
  parameter int PERIOD_CYC = 50_000_000,
  parameter logic signed [15:0] ALARM_HI = 16'sd480
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic auto_en,
  ds_scan_multi_if.master intf,
  output logic [15:0] temp_out,
  output logic [CH_W-1:0] temp_ch,
  output logic temp_vld,
  output logic [CH_NUM-1:0] alarm,
  input logic [CH_NUM-1:0] alarm_clr,
  output logic crc_err,
  output logic busy
);
  typedef enum logic [3:0] {IDLE, B_RST, B_SKIP, B_CONV, WAIT_CONV, C_RST, C_MATCH, C_ROM, C_RDSP, C_READ, C_DONE} state_t;
  state_t st;
  logic [1:0] ph;
  logic [CH_W-1:0] ch;
  logic [3:0] bcnt;
  logic [31:0] cnt, pcnt;
  logic [7:0] b0, wd;
  logic [15:0] res_t;
  logic is_rst, is_rd, is_step, done, last, res_ok, go;
  logic [CH_NUM-1:0] alarm_set;
`ifdef DS_SCAN_CRC_EN
  localparam int NRD = 9;
  logic [7:0] b1, crc;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 8'h8C : 8'h00);
    return r;
  endfunction
  assign res_t = {b1, b0};
  assign res_ok = crc == intf.rdata;
`else
  localparam int NRD = 2;
  assign res_t = {intf.rdata, b0};
  assign res_ok = 1'b1;
  assign crc_err = 1'b0;
`endif
  // step classification, completion detect, write byte select and alarm set decode
  always_comb begin
    is_rst = st == B_RST || st == C_RST;
    is_rd = st == C_READ;
    is_step = st != IDLE && st != WAIT_CONV && st != C_DONE;
    done = ph == 2'd3 && (is_rd ? intf.rdata_vld : intf.rdy);
    last = done && is_rd && bcnt == 4'(NRD - 1);
    wd = st == B_SKIP ? 8'hCC : st == B_CONV ? 8'h44 : st == C_MATCH ? 8'h55 : st == C_RDSP ? 8'hBE : ROM_CODES[{ch, bcnt[2:0], 3'b000} +: 8];
    alarm_set = (last && res_ok && $signed(res_t) > ALARM_HI) ? CH_NUM'(1) << ch : '0;
    go = start || (auto_en && pcnt == 32'(PERIOD_CYC - 1));
  end
  // scan FSM: issue/ignore/complete handshake per step, result capture, alarms and period counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ph <= '0;
      ch <= '0;
      bcnt <= '0;
      cnt <= '0;
      pcnt <= '0;
      b0 <= '0;
      intf.rst_en <= 1'b0;
      intf.wr_en <= 1'b0;
      intf.rd_en <= 1'b0;
      intf.wdata <= '0;
      temp_out <= '0;
      temp_ch <= '0;
      temp_vld <= 1'b0;
      alarm <= '0;
      busy <= 1'b0;
`ifdef DS_SCAN_CRC_EN
      b1 <= '0;
      crc <= '0;
      crc_err <= 1'b0;
`endif
    end else begin
      intf.rst_en <= 1'b0;
      intf.wr_en <= 1'b0;
      intf.rd_en <= 1'b0;
      temp_vld <= 1'b0;
`ifdef DS_SCAN_CRC_EN
      crc_err <= 1'b0;
`endif
      alarm <= (alarm & ~alarm_clr) | alarm_set;
      pcnt <= (st == IDLE && go) ? '0 : pcnt == 32'(PERIOD_CYC - 1) ? pcnt : pcnt + 32'd1;
      if (is_step) begin
        if (ph == 2'd0 && intf.rdy) begin
          intf.rst_en <= is_rst;
          intf.wr_en <= !is_rst && !is_rd;
          intf.rd_en <= is_rd;
          if (!is_rst && !is_rd) intf.wdata <= wd;
          ph <= 2'd1;
        end else if (ph == 2'd1 || ph == 2'd2) ph <= ph + 2'd1;
        else if (done) ph <= 2'd0;
      end
      case (st)
        IDLE: if (go) begin st <= B_RST; busy <= 1'b1; end
        B_RST: if (done) st <= B_SKIP;
        B_SKIP: if (done) st <= B_CONV;
        B_CONV: if (done) begin st <= WAIT_CONV; cnt <= '0; end
        WAIT_CONV: if (cnt == 32'(CONV_CYC - 1)) begin st <= C_RST; ch <= '0; end else cnt <= cnt + 32'd1;
        C_RST: if (done) st <= C_MATCH;
        C_MATCH: if (done) begin st <= C_ROM; bcnt <= '0; end
        C_ROM: if (done) begin bcnt <= bcnt + 4'd1; if (bcnt == 4'd7) st <= C_RDSP; end
        C_RDSP: if (done) begin
          st <= C_READ;
          bcnt <= '0;
`ifdef DS_SCAN_CRC_EN
          crc <= '0;
`endif
        end
        C_READ: if (done) begin
          bcnt <= bcnt + 4'd1;
          if (bcnt == 4'd0) b0 <= intf.rdata;
`ifdef DS_SCAN_CRC_EN
          if (bcnt == 4'd1) b1 <= intf.rdata;
          if (bcnt < 4'd8) crc <= crc8(crc, intf.rdata);
          crc_err <= last && !res_ok;
`endif
          if (last) begin
            st <= C_DONE;
            temp_vld <= res_ok;
            if (res_ok) begin temp_out <= res_t; temp_ch <= ch; end
          end
        end
        C_DONE: if (ch == CH_W'(CH_NUM - 1)) begin st <= IDLE; busy <= 1'b0; end else begin ch <= ch + 1'b1; st <= C_RST; end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ds_scan_multi.sv
// tb_ds_scan_multi: directed bench with a byte-layer model for the two-sensor scan controller
module tb_ds_scan_multi;
  localparam logic [63:0] ROM0 = 64'h9E00_0007_1A2B_3C28;
  localparam logic [63:0] ROM1 = 64'h4F00_0009_8D7E_6F28;
`ifdef DS_SCAN_CRC_EN
  localparam int NRD = 9;
`else
  localparam int NRD = 2;
`endif
  logic clk = 0, rst = 1, start = 0, auto_en = 0;
  logic [1:0] man_clr = 0, clr_pulse = 0, alarm_clr, alarm;
  logic [15:0] temp_out;
  logic temp_ch, temp_vld, crc_err, busy;
  ds_scan_multi_if intf();
  assign alarm_clr = man_clr | clr_pulse;
  ds_scan_multi #(.CH_NUM(2), .CH_W(1), .ROM_CODES({ROM1, ROM0}), .CONV_CYC(100), .PERIOD_CYC(2000), .ALARM_HI(16'sd480)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .intf(intf),
    .temp_out(temp_out), .temp_ch(temp_ch), .temp_vld(temp_vld), .alarm(alarm),
    .alarm_clr(alarm_clr), .crc_err(crc_err), .busy(busy));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int mcnt = 0, wcnt = 0, ridx = 0, sel = 0, viol = 0, n_rst = 0, n_crc = 0, n_late = 0, last_rst_t = 0;
  logic op_rd = 0, clr_mode = 0;
  logic [63:0] rom_cap = 0;
  logic [7:0] sp [2][9];
  logic [7:0] wlog [$];
  logic [16:0] res_q [$];
  int scan_t [$];
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask
  function automatic logic [7:0] tb_crc(input logic [63:0] v);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ v[i];
      c = {fb, c[7:1]} ^ {4'b0000, fb, fb, 2'b00};
    end
    return c;
  endfunction
  task automatic load(input int c, input logic [15:0] t);
    logic [63:0] v;
    v = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t[15:8], t[7:0]};
    for (int i = 0; i < 8; i++) sp[c][i] = v[8*i +: 8];
    sp[c][8] = tb_crc(v);
  endtask
  // byte-layer model and output monitor, both acting away from the DUT clock edge
  always @(negedge clk) begin
    if (temp_vld) begin res_q.push_back({temp_ch, temp_out}); if (!intf.rdata_vld) n_late++; end
    if (crc_err) begin n_crc++; if (!intf.rdata_vld) n_late++; end
    intf.rdata_vld = 0;
    clr_pulse = 0;
    if (rst) begin
      mcnt = 0;
      intf.rdy = 1;
    end else if (intf.rst_en || intf.wr_en || intf.rd_en) begin
      if (mcnt != 0 || (32'(intf.rst_en) + 32'(intf.wr_en) + 32'(intf.rd_en)) != 1) viol++;
      mcnt = 3;
      intf.rdy = 0;
      op_rd = intf.rd_en;
      if (intf.rst_en) begin n_rst++; wcnt = 0; ridx = 0; last_rst_t = cyc; end
      if (intf.wr_en) begin
        wlog.push_back(intf.wdata);
        if (wcnt == 0 && intf.wdata == 8'hCC) scan_t.push_back(last_rst_t);
        if (wcnt >= 1 && wcnt <= 8) rom_cap[8*(wcnt-1) +: 8] = intf.wdata;
        if (wcnt == 8) sel = (rom_cap == ROM1) ? 1 : 0;
        wcnt++;
      end
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        intf.rdy = 1;
        if (op_rd) begin
          intf.rdata_vld = 1;
          intf.rdata = (ridx < 9) ? sp[sel][ridx] : 8'h00;
          if (clr_mode && sel == 1 && ridx == NRD - 1) clr_pulse = 2'b10;
          ridx++;
        end
      end
    end
  end
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check(tag, 64'(n < 5000), 64'd1);
  endtask
  task automatic pulse_start(input string tag, input logic exp_busy);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check(tag, 64'(busy), 64'(exp_busy));
  endtask
  task automatic new_scan();
    wlog.delete();
    res_q.delete();
    n_rst = 0;
    n_crc = 0;
  endtask
  task automatic check_res(input string tag, input int i, input logic [16:0] exp);
    check(tag, 64'((res_q.size() > i) ? res_q[i] : 17'h1FFFF), 64'(exp));
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_temp_out"}, 64'(temp_out), 64'd0);
    check({tag, "_temp_ch"}, 64'(temp_ch), 64'd0);
    check({tag, "_temp_vld"}, 64'(temp_vld), 64'd0);
    check({tag, "_alarm"}, 64'(alarm), 64'd0);
    check({tag, "_crc_err"}, 64'(crc_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_en"}, 64'({intf.rst_en, intf.wr_en, intf.rd_en}), 64'd0);
    check({tag, "_wdata"}, 64'(intf.wdata), 64'd0);
  endtask
  initial begin
    logic [7:0] exp_w [$];
    logic [63:0] r;
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    // two channels, ch1 above threshold
    load(0, 16'h0191);
    load(1, 16'h0550);
    new_scan();
    pulse_start("scan1_busy_rise", 1);
    wait_idle("scan1_done");
    check("scan1_nres", 64'(res_q.size()), 64'd2);
    check_res("scan1_ch0", 0, {1'b0, 16'h0191});
    check_res("scan1_ch1", 1, {1'b1, 16'h0550});
    check("scan1_alarm", 64'(alarm), 64'b10);
    check("scan1_nrst", 64'(n_rst), 64'd3);
    check("scan1_nwr", 64'(wlog.size()), 64'd22);
    exp_w = {8'hCC, 8'h44};
    for (int c = 0; c < 2; c++) begin
      r = c ? ROM1 : ROM0;
      exp_w.push_back(8'h55);
      for (int i = 0; i < 8; i++) exp_w.push_back(r[8*i +: 8]);
      exp_w.push_back(8'hBE);
    end
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("scan1_wbyte%0d", i), 64'((wlog.size() > i) ? {1'b0, wlog[i]} : 9'h100), 64'({1'b0, exp_w[i]}));
    // negative reading, clear colliding with a new ch1 set, start pulses while busy
    load(0, 16'hFF5E);
    clr_mode = 1;
    new_scan();
    pulse_start("scan2_busy_rise", 1);
    repeat (60) @(negedge clk);
    pulse_start("scan2_start_busy_a", 1);
    repeat (100) @(negedge clk);
    pulse_start("scan2_start_busy_b", 1);
    wait_idle("scan2_done");
    clr_mode = 0;
    repeat (50) @(negedge clk);
    check("scan2_no_rescan", 64'(busy), 64'd0);
    check("scan2_nrst", 64'(n_rst), 64'd3);
    check_res("scan2_ch0_neg", 0, {1'b0, 16'hFF5E});
    check_res("scan2_ch1", 1, {1'b1, 16'h0550});
    check("scan2_alarm_set_wins", 64'(alarm), 64'b10);
    man_clr = 2'b10;
    @(negedge clk);
    man_clr = 0;
    check("clr_alone", 64'(alarm), 64'b00);
    // threshold boundary: equal is not over
    load(0, 16'h01E0);
    load(1, 16'h01E1);
    new_scan();
    pulse_start("scan3_busy_rise", 1);
    wait_idle("scan3_done");
    check_res("scan3_ch0", 0, {1'b0, 16'h01E0});
    check_res("scan3_ch1", 1, {1'b1, 16'h01E1});
    check("scan3_alarm", 64'(alarm), 64'b10);
    // reset during ch1 ROM bytes, then a clean rescan
    load(0, 16'h0123);
    load(1, 16'h0456);
    new_scan();
    pulse_start("scan4_busy_rise", 1);
    n = 0;
    while (wlog.size() < 15 && n < 5000) begin @(negedge clk); n++; end
    check("scan4_reach_rom1", 64'(n < 5000), 64'd1);
    rst = 1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 0;
    repeat (10) @(negedge clk);
    new_scan();
    pulse_start("scan5_busy_rise", 1);
    wait_idle("scan5_done");
    check_res("scan5_ch0", 0, {1'b0, 16'h0123});
    check_res("scan5_ch1", 1, {1'b1, 16'h0456});
    check("scan5_nrst", 64'(n_rst), 64'd3);
`ifdef DS_SCAN_CRC_EN
    // literal 85 C scratchpad with its CRC, then a corrupted CRC byte
    load(0, 16'h0191);
    load(1, 16'h0550);
    sp[1][8] = 8'h1C;
    new_scan();
    pulse_start("crc_ok_busy_rise", 1);
    wait_idle("crc_ok_done");
    check_res("crc_ok_ch1", 1, {1'b1, 16'h0550});
    check("crc_ok_nerr", 64'(n_crc), 64'd0);
    man_clr = 2'b11;
    @(negedge clk);
    man_clr = 0;
    sp[1][8] = 8'h1D;
    new_scan();
    pulse_start("crc_bad_busy_rise", 1);
    wait_idle("crc_bad_done");
    check("crc_bad_nerr", 64'(n_crc), 64'd1);
    check("crc_bad_nres", 64'(res_q.size()), 64'd1);
    check_res("crc_bad_ch0", 0, {1'b0, 16'h0191});
    check("crc_bad_temp_kept", 64'(temp_out), 64'h0191);
    check("crc_bad_alarm", 64'(alarm), 64'b00);
`endif
    // periodic auto-scan with stray starts while busy
    scan_t.delete();
    auto_en = 1;
    n = 0;
    while (scan_t.size() < 4 && n < 12000) begin
      @(negedge clk);
      n++;
      start = busy && (n % 700 == 350);
    end
    start = 0;
    auto_en = 0;
    check("auto_reach", 64'(scan_t.size() >= 4), 64'd1);
    for (int i = 1; i < 4; i++)
      check($sformatf("auto_period%0d", i), 64'((scan_t.size() > i) ? scan_t[i] - scan_t[i-1] : 0), 64'd2000);
    wait_idle("auto_done");
    check("late_vld", 64'(n_late), 64'd0);
    check("handshake_viol", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
